// File: rtl/fir_sample_source.sv
// -----------------------------------------------------------------------------
// fir_sample_source
//
// Preloadable sample feeder for the FIR input port. Up to DEPTH samples are
// written into a local buffer while idle. A start pulse then streams them out
// over a valid/ready handshake, either once or looping. A programmable number
// of idle cycles can be inserted after each accepted sample.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   wr_en/wr_data append one sample to the buffer (idle only, ignored when full)
//   clear         empty the buffer (idle only, wins over wr_en)
//   start         begin streaming (single-cycle pulse, ignored if busy/empty)
//   abort         return to idle at once, without a done pulse
//   loop_en       wrap to entry 0 after the last entry instead of finishing
//   rate_div      idle cycles inserted after each accepted sample
//   sample_out    sample presented to the FIR
//   sample_valid  sample_out is valid
//   sample_ready  FIR accepts the sample
//   full          buffer holds DEPTH entries (registered)
//   busy          streaming (SEND or GAP)
//   done          one-cycle pulse after the last sample of a non-loop pass
//
// Optional build macro FIR_SRC_SAMPLE_CNT_EN adds sample_cnt[15:0], a
// wrapping count of accepted handshakes, cleared by reset and by start.
// -----------------------------------------------------------------------------
module fir_sample_source #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int PTR_W  = 3,
   parameter int DIV_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clear,
   input  logic              start,
   input  logic              abort,
   input  logic              loop_en,
   input  logic [DIV_W-1:0]  rate_div,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              full,
   output logic              busy,
   output logic              done
`ifdef FIR_SRC_SAMPLE_CNT_EN
   ,
   output logic [15:0]       sample_cnt
`endif
);

   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_idx_q, rd_idx_d;
   logic [DIV_W-1:0]  gap_q, gap_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              full_q, full_d;
   logic              done_q, done_d;

   logic              handshake;
   logic              last_entry;
   logic              start_ok;

   assign handshake  = (state_q == SEND) && sample_ready;
   assign last_entry = (rd_idx_q == PTR_W'(count_q - CNT_W'(1)));
   assign start_ok   = (state_q == IDLE) && start && (count_q != '0);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: the buffer is reset explicitly so every entry reads 0 after reset;
   // that rules out mapping it onto a RAM macro.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rd_idx_q <= '0;
         gap_q    <= '0;
         full_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge value of the others, independent of statement order.
         state_q  <= state_d;
         count_q  <= count_d;
         rd_idx_q <= rd_idx_d;
         gap_q    <= gap_d;
         full_q   <= full_d;
         done_q   <= done_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d  = state_q;
      count_d  = count_q;
      rd_idx_d = rd_idx_q;
      gap_d    = gap_q;
      done_d   = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

      unique case (state_q)
         IDLE: begin
            if (clear) begin
               count_d = '0;
            end else if (wr_en && !full_q) begin
               mem_d[count_q[PTR_W-1:0]] = wr_data;
               count_d = count_q + CNT_W'(1);
            end
            if (start_ok) begin
               state_d  = SEND;
               rd_idx_d = '0;
            end
         end

         SEND: begin
            // abort wins over a simultaneous handshake; the FIR still took
            // the sample, but the pass ends here without done.
            if (abort) begin
               state_d = IDLE;
            end else if (handshake) begin
               if (last_entry && !loop_en) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  rd_idx_d = last_entry ? '0 : rd_idx_q + PTR_W'(1);
                  if (rate_div != '0) begin
                     state_d = GAP;
                     gap_d   = rate_div;
                  end
               end
            end
         end

         GAP: begin
            // gap_q counts the low-valid cycles still to go, including this one
            if (abort) begin
               state_d = IDLE;
            end else if (gap_q <= DIV_W'(1)) begin
               state_d = SEND;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - DIV_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      full_d = (count_d == CNT_W'(DEPTH));
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      sample_valid = (state_q == SEND);
      busy         = (state_q != IDLE);
      sample_out   = sample_valid ? mem_q[rd_idx_q] : '0;
      full         = full_q;
      done         = done_q;
   end

`ifdef FIR_SRC_SAMPLE_CNT_EN
   logic [15:0] sample_cnt_q, sample_cnt_d;

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      if (start_ok)       sample_cnt_d = '0;
      else if (handshake) sample_cnt_d = sample_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sample_cnt_q <= '0;
      else        sample_cnt_q <= sample_cnt_d;
   end

   assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_fir_sample_source.sv
// -----------------------------------------------------------------------------
// tb_fir_sample_source
//
// Self-checking bench for fir_sample_source. A queue holds the samples the
// buffer should contain; each pass is predicted from that queue, the rate
// setting and the ready pattern the bench chooses.
// -----------------------------------------------------------------------------
module tb_fir_sample_source;

   localparam int DATA_W = 4;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   localparam int DIV_W  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              clear = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              loop_en = 1'b0;
   logic [DIV_W-1:0]  rate_div = '0;
   logic              sample_ready = 1'b0;
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;
   logic              full;
   logic              busy;
   logic              done;
`ifdef FIR_SRC_SAMPLE_CNT_EN
   logic [15:0]       sample_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] mdl_buf [$];

   fir_sample_source #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .DIV_W(DIV_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .clear       (clear),
      .start       (start),
      .abort       (abort),
      .loop_en     (loop_en),
      .rate_div    (rate_div),
      .sample_out  (sample_out),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .full        (full),
      .busy        (busy),
      .done        (done)
`ifdef FIR_SRC_SAMPLE_CNT_EN
      ,
      .sample_cnt  (sample_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      if (mdl_buf.size() < DEPTH) mdl_buf.push_back(d);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mdl_buf.delete();
   endtask

   // Single-shot pass over the model queue. Valid is expected whenever no
   // gap cycles are outstanding; each accepted sample opens 'rate' low cycles.
   task automatic run_pass(input string name, input int rate, input int ready_pct,
                           output int cycles);
      int  k, gap_left, budget;
      bit  hs, finished;
      rate_div = DIV_W'(rate);
      loop_en  = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      k = 0; gap_left = 0; cycles = 0; budget = 0; finished = 0;
      while (!finished && budget < 1000) begin
         total++;
         if ({busy, sample_valid, done} !== {1'b1, gap_left == 0, 1'b0}) begin
            bad++;
            $display("FAIL %s ctrl k=%0d busy/valid/done got=%b exp=%b", name, k,
                     {busy, sample_valid, done}, {1'b1, gap_left == 0, 1'b0});
         end
         if (gap_left == 0) begin
            total++;
            if (sample_out !== mdl_buf[k]) begin
               bad++;
               $display("FAIL %s data k=%0d got=%h exp=%h", name, k, sample_out, mdl_buf[k]);
            end
         end
         sample_ready = ($urandom_range(99) < ready_pct);
         hs = (gap_left == 0) && sample_ready;
         tick();
         cycles++; budget++;
         if (hs) begin
            k++;
            if (k == mdl_buf.size()) finished = 1;
            else gap_left = rate;
         end else if (gap_left > 0) begin
            gap_left--;
         end
      end
      sample_ready = 1'b0;
      total++;
      if (!finished) begin
         bad++;
         $display("FAIL %s timeout after %0d cycles", name, budget);
      end else if ({busy, sample_valid, done} !== 3'b001) begin
         bad++;
         $display("FAIL %s end busy/valid/done got=%b exp=001", name,
                  {busy, sample_valid, done});
      end
`ifdef FIR_SRC_SAMPLE_CNT_EN
      total++;
      if (sample_cnt !== 16'(mdl_buf.size())) begin
         bad++;
         $display("FAIL %s sample_cnt got=%0d exp=%0d", name, sample_cnt, mdl_buf.size());
      end
`endif
      tick();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL %s done_width got=%b exp=0", name, done);
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({sample_out, sample_valid, full, busy, done} !== '0) begin
         bad++;
         $display("FAIL reset outputs got=%b exp=0",
                  {sample_out, sample_valid, full, busy, done});
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_pass();
      int cyc;
      // clear beats a simultaneous write
      clear = 1'b1; wr_en = 1'b1; wr_data = 4'h9;
      tick();
      clear = 1'b0; wr_en = 1'b0;
      mdl_buf.delete();
      do_write(4'h3); do_write(4'h7); do_write(4'hA);
      run_pass("single", 0, 100, cyc);
      total++;
      if (cyc !== 3) begin
         bad++;
         $display("FAIL single cycles got=%0d exp=3", cyc);
      end
   endtask

   task automatic test_full();
      int cyc;
      do_clear();
      for (int i = 0; i < DEPTH - 1; i++) do_write(DATA_W'(i));
      total++;
      if (full !== 1'b0) begin
         bad++;
         $display("FAIL full_at_7 got=%b exp=0", full);
      end
      do_write(4'h7);
      total++;
      if (full !== 1'b1) begin
         bad++;
         $display("FAIL full_at_8 got=%b exp=1", full);
      end
      do_write(4'hF);
      run_pass("full", 0, 100, cyc);
      total++;
      if (cyc !== DEPTH) begin
         bad++;
         $display("FAIL full cycles got=%0d exp=%0d", cyc, DEPTH);
      end
   endtask

   task automatic test_gap();
      int cyc;
      do_clear();
      do_write(4'h3); do_write(4'h7); do_write(4'hA);
      run_pass("gap", 2, 100, cyc);
      total++;
      if (cyc !== 7) begin
         bad++;
         $display("FAIL gap cycles got=%0d exp=7", cyc);
      end
   endtask

   task automatic test_loop_abort();
      int cyc;
      logic [DATA_W-1:0] exp_d;
      do_clear();
      do_write(4'h1); do_write(4'h2);
      loop_en = 1'b1; rate_div = '0; sample_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp_d = (i % 2 == 0) ? 4'h1 : 4'h2;
         total++;
         if ({sample_valid, done, sample_out} !== {1'b1, 1'b0, exp_d}) begin
            bad++;
            $display("FAIL loop i=%0d valid/done/data got=%b exp=%b", i,
                     {sample_valid, done, sample_out}, {1'b1, 1'b0, exp_d});
         end
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0; sample_ready = 1'b0;
      total++;
      if ({busy, sample_valid, done} !== 3'b000) begin
         bad++;
         $display("FAIL abort busy/valid/done got=%b exp=000", {busy, sample_valid, done});
      end
      tick();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL abort late_done got=%b exp=0", done);
      end
      // buffer and count survive the abort
      run_pass("after_abort", 0, 100, cyc);
      total++;
      if (cyc !== 2) begin
         bad++;
         $display("FAIL after_abort cycles got=%0d exp=2", cyc);
      end
   endtask

   task automatic test_backpressure();
      do_clear();
      do_write(4'h5); do_write(4'h6);
      rate_div = '0; loop_en = 1'b0; sample_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({sample_valid, sample_out} !== {1'b1, 4'h5}) begin
            bad++;
            $display("FAIL stall i=%0d valid/data got=%b exp=%b", i,
                     {sample_valid, sample_out}, {1'b1, 4'h5});
         end
         tick();
      end
      sample_ready = 1'b1;
      tick();
      total++;
      if ({sample_valid, sample_out} !== {1'b1, 4'h6}) begin
         bad++;
         $display("FAIL stall_release valid/data got=%b exp=%b",
                  {sample_valid, sample_out}, {1'b1, 4'h6});
      end
      tick();
      sample_ready = 1'b0;
      total++;
      if ({busy, done} !== 2'b01) begin
         bad++;
         $display("FAIL stall_end busy/done got=%b exp=01", {busy, done});
      end
      tick();
   endtask

   task automatic test_random();
      int cyc, n;
      for (int it = 0; it < 6; it++) begin
         do_clear();
         n = $urandom_range(DEPTH, 1);
         for (int j = 0; j < n; j++) do_write(DATA_W'($urandom_range(15)));
         run_pass($sformatf("rand%0d", it), $urandom_range(3), 60, cyc);
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      for (int i = 0; i < DEPTH; i++) do_write(DATA_W'($urandom_range(15)));
      rate_div = 4'd1; loop_en = 1'b0; sample_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      sample_ready = 1'b0;
      total++;
      if ({sample_valid, busy, full, done} !== 4'b0000) begin
         bad++;
         $display("FAIL async_reset valid/busy/full/done got=%b exp=0000",
                  {sample_valid, busy, full, done});
      end
      @(negedge clk);
      reset = 1'b1;
      mdl_buf.delete();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({sample_valid, busy, done} !== 3'b000) begin
         bad++;
         $display("FAIL empty_start valid/busy/done got=%b exp=000",
                  {sample_valid, busy, done});
      end
`ifdef FIR_SRC_SAMPLE_CNT_EN
      total++;
      if (sample_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset sample_cnt got=%0d exp=0", sample_cnt);
      end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_full();
      test_gap();
      test_loop_abort();
      test_backpressure();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
